wb_host_master: RTL
===================

Name: wb_host_master

Overview:
Single-outstanding Wishbone classic master. It converts a valid/ready host request channel (from the UART/CSR command decoder) into one Wishbone cycle, and returns read data and status on a valid/ready response channel. It sits directly upstream of the Wishbone interconnect and drives its master port. Requests to unmapped slave indices and requests that time out complete with an error flag and never hang the bus.

Parameters:
NUM_SLAVE, 3, number of slaves behind the interconnect; slave index is addr[15:8]
TIMEOUT, 255, max cycles cyc/stb stay asserted waiting for ack (legal 2..65535)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
i_req_valid  input  1  host request valid
o_req_ready  output  1  host request accepted when valid&ready
i_req_we  input  1  1=write, 0=read
i_req_addr  input  32  byte address; [15:8] selects slave
i_req_wdata  input  32  write data
o_rsp_valid  output  1  response valid
i_rsp_ready  input  1  host consumes response
o_rsp_rdata  output  32  read data (0 for writes and errors)
o_rsp_err  output  1  1=timeout or unmapped slave
o_wbm_cyc  output  1  Wishbone cycle
o_wbm_stb  output  1  Wishbone strobe
o_wbm_we  output  1  Wishbone write enable
o_wbm_addr  output  32  Wishbone address
o_wbm_data  output  32  Wishbone write data
i_wbm_data  input  32  Wishbone read data
i_wbm_ack  input  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0, async): state IDLE; o_wbm_cyc/stb/we=0, o_wbm_addr/data=0, o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, timeout counter=0. Reset mid-cycle drops cyc/stb immediately.
- All outputs are registered, except o_req_ready = (state==IDLE).
- FSM: IDLE, BUS, RESP.
- IDLE: on i_req_valid, latch we/addr/wdata.
  - If addr[15:8] >= NUM_SLAVE: go to RESP with err=1, rdata=0; no Wishbone cycle is issued.
  - Otherwise go to BUS with cyc=stb=1, we/addr/data driven from the latched values, counter=0.
- BUS: cyc, stb, we, addr and data are held stable every cycle.
  - Ack sampled high: capture i_wbm_data into rdata (reads) or 0 (writes), err=0, deassert cyc/stb/we next edge, go to RESP.
  - Else if counter==TIMEOUT-1: deassert cyc/stb, rdata=0, err=1, go to RESP.
  - Else counter++.
  - Ack in the same cycle as the timeout expiry: ack wins, err=0.
- RESP: o_rsp_valid=1, rdata/err stable until i_rsp_ready. On the handshake, valid=0 and go to IDLE. The next request can be accepted the cycle after.
- Latency with zero-wait slave (ack combinational on stb): request accepted cycle 0, cyc/stb high cycle 1, ack cycle 1, o_rsp_valid cycle 2. Wishbone cycle width = 1 + wait states.
- Ack while in IDLE or RESP is ignored.
- Request valid while not IDLE is not accepted (ready=0); the host holds it.
- Counter width is clog2(TIMEOUT+1) and saturates; it never wraps.

Decomposition:
- Shared package wb_pkg: state encoding (IDLE=0, BUS=1, RESP=2), WB_ADDR_W=32, WB_DATA_W=32, SLAVE_SEL_MSB=15, SLAVE_SEL_LSB=8. The interconnect uses the same select constants.
- One natural sub-module: wb_timeout_cnt (clear, enable, expired output; parameter TIMEOUT).

Test Plan:
- Write 0x0000_0110 data 0xCAFE_F00D, slave 1 acks after 2 wait cycles -> cyc/stb high exactly 3 cycles, we=1, addr/data stable; response valid with err=0, rdata=0.
- Read 0x0000_0004, slave 0 acks in the first cyc cycle with data 0x1234_5678 -> o_rsp_valid on cycle 2, rdata=0x1234_5678, err=0.
- Read 0x0000_0500 (slave 5, NUM_SLAVE=3) -> cyc never asserted; response err=1, rdata=0, one cycle after accept.
- TIMEOUT=8, slave never acks -> cyc/stb high exactly 8 cycles then low; response err=1, rdata=0. Repeat with ack on the 8th cycle -> err=0, data captured.
- Hold i_rsp_ready=0 for 5 cycles with a second request pending -> rsp_valid/rdata stable, req_ready=0, no new cyc. After ready, the second request is accepted one cycle after the handshake.
- Assert rst=0 for 1 cycle mid-BUS -> cyc/stb/rsp_valid=0 immediately, FSM in IDLE, and a new request then completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone state encoding, bus widths and slave-select field.
package wb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int SLAVE_SEL_MSB = 15;
  localparam int SLAVE_SEL_LSB = 8;
  function automatic logic [SLAVE_SEL_MSB-SLAVE_SEL_LSB:0] slave_sel(input logic [WB_ADDR_W-1:0] a);
    return a[SLAVE_SEL_MSB:SLAVE_SEL_LSB];
  endfunction
endpackage

// File: rtl/wb_host_master_if.sv
// wb_host_master_if: host request/response channel plus Wishbone master port.
interface wb_host_master_if;
  import wb_pkg::*;
  logic                 i_req_valid, o_req_ready, i_req_we;
  logic [WB_ADDR_W-1:0] i_req_addr;
  logic [WB_DATA_W-1:0] i_req_wdata;
  logic                 o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic [WB_DATA_W-1:0] o_rsp_rdata;
  logic                 o_wbm_cyc, o_wbm_stb, o_wbm_we, i_wbm_ack;
  logic [WB_ADDR_W-1:0] o_wbm_addr;
  logic [WB_DATA_W-1:0] o_wbm_data, i_wbm_data;
  modport master (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready, i_wbm_data, i_wbm_ack,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_addr, o_wbm_data
  );
  modport slave (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_rsp_ready, i_wbm_data, i_wbm_ack,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_wbm_cyc, o_wbm_stb, o_wbm_we, o_wbm_addr, o_wbm_data
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: saturating cycle counter flagging the last allowed wait cycle.
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != W'(TIMEOUT)) cnt <= cnt + W'(1);
  assign expired = cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding Wishbone classic master behind a valid/ready host channel.
module wb_host_master import wb_pkg::*; #(
  parameter int NUM_SLAVE = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_host_master_if.master  bus
);
  state_t               state, state_n;
  logic                 cyc, cyc_n, we, we_n, rvalid, rvalid_n, err, err_n;
  logic                 expired, unmapped;
  logic [WB_ADDR_W-1:0] addr, addr_n;
  logic [WB_DATA_W-1:0] data, data_n, rdata, rdata_n;
  assign unmapped = 32'(slave_sel(bus.i_req_addr)) >= NUM_SLAVE;
  wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != BUS),
    .en      (state == BUS),
    .expired (expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= IDLE;
      cyc    <= 1'b0;
      we     <= 1'b0;
      addr   <= '0;
      data   <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cyc    <= cyc_n;
      we     <= we_n;
      addr   <= addr_n;
      data   <= data_n;
      rvalid <= rvalid_n;
      rdata  <= rdata_n;
      err    <= err_n;
    end
  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    we_n     = we;
    addr_n   = addr;
    data_n   = data;
    rvalid_n = rvalid;
    rdata_n  = rdata;
    err_n    = err;
    case (state)
      IDLE: if (bus.i_req_valid) begin
        if (unmapped) begin
          state_n  = RESP;
          rvalid_n = 1'b1;
          rdata_n  = '0;
          err_n    = 1'b1;
        end else begin
          state_n = BUS;
          cyc_n   = 1'b1;
          we_n    = bus.i_req_we;
          addr_n  = bus.i_req_addr;
          data_n  = bus.i_req_wdata;
        end
      end
      BUS: if (bus.i_wbm_ack || expired) begin
        state_n  = RESP;
        cyc_n    = 1'b0;
        we_n     = 1'b0;
        rvalid_n = 1'b1;
        rdata_n  = (bus.i_wbm_ack && !we) ? bus.i_wbm_data : '0;
        err_n    = !bus.i_wbm_ack;
      end
      RESP: if (bus.i_rsp_ready) begin
        state_n  = IDLE;
        rvalid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.o_req_ready = state == IDLE;
  assign bus.o_rsp_valid = rvalid;
  assign bus.o_rsp_rdata = rdata;
  assign bus.o_rsp_err   = err;
  assign bus.o_wbm_cyc   = cyc;
  assign bus.o_wbm_stb   = cyc;
  assign bus.o_wbm_we    = we;
  assign bus.o_wbm_addr  = addr;
  assign bus.o_wbm_data  = data;
endmodule
